// File: rtl/prefetch_unit.sv
// Instruction prefetch unit: credit-limited fetch requests, in-order response
// queue toward decode, and redirect handling that drains stale responses.
module prefetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,

    output logic                       o_im_req_valid,
    input  logic                       i_im_req_ready,
    output logic [XLEN-1:0]            o_im_req_addr,

    input  logic                       i_im_rsp_valid,
    input  logic [XLEN-1:0]            i_im_rsp_data,

    output logic                       o_ins_valid,
    input  logic                       i_ins_ready,
    output logic [XLEN-1:0]            o_ins_data,
    output logic [XLEN-1:0]            o_ins_pc,

    input  logic                       i_redirect_valid,
    input  logic [XLEN-1:0]            i_redirect_pc,

    output logic                       o_flushing,
    output logic [$clog2(DEPTH):0]     o_outstanding
);

    localparam int             PW        = $clog2(DEPTH);
    localparam int             CW        = PW + 1;
    localparam logic [CW:0]    DEPTH_LIM = (CW + 1)'(DEPTH);

    typedef enum logic {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t          state;
    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   count;
    logic [CW-1:0]   outstanding;

    // Decode-side instruction queue.
    logic [XLEN-1:0] q_data [DEPTH];
    logic [XLEN-1:0] q_pc   [DEPTH];
    logic [PW-1:0]   q_head;
    logic [PW-1:0]   q_tail;

    // Addresses of requests in flight, oldest at pf_head; responses pop it
    // even while flushing so it always mirrors the outstanding count.
    logic [XLEN-1:0] pc_fifo [DEPTH];
    logic [PW-1:0]   pf_head;
    logic [PW-1:0]   pf_tail;

    logic            credit_ok;
    logic            req_fire;
    logic            rsp_accept;
    logic            enq;
    logic            deq;
    logic [CW-1:0]   out_next;

    always_comb begin
        credit_ok      = ({1'b0, count} + {1'b0, outstanding}) < DEPTH_LIM;
        o_im_req_valid = !rst && (state == FETCH) && credit_ok && !i_redirect_valid;
        req_fire       = o_im_req_valid && i_im_req_ready;
        // A response with nothing in flight is a protocol violation; drop it.
        rsp_accept     = i_im_rsp_valid && (outstanding != '0);
        enq            = rsp_accept && (state == FETCH) && !i_redirect_valid;
        deq            = o_ins_valid && i_ins_ready;
        out_next       = outstanding + CW'(req_fire) - CW'(rsp_accept);
    end

    assign o_im_req_addr = fetch_pc;
    assign o_ins_valid   = (count != '0);
    assign o_ins_data    = q_data[q_head];
    assign o_ins_pc      = q_pc[q_head];
    assign o_flushing    = (state == FLUSH);
    assign o_outstanding = outstanding;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            fetch_pc    <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            q_head      <= '0;
            q_tail      <= '0;
            pf_head     <= '0;
            pf_tail     <= '0;
            // NOTE: queue storage is cleared on reset so the data/pc outputs
            // read zero while idle; the arrays are small enough to stay flops.
            for (int i = 0; i < DEPTH; i++) begin
                q_data[i]  <= '0;
                q_pc[i]    <= '0;
                pc_fifo[i] <= '0;
            end
        end else begin
            outstanding <= out_next;

            if (req_fire) begin
                pc_fifo[pf_tail] <= fetch_pc;
                pf_tail          <= pf_tail + PW'(1);
                fetch_pc         <= fetch_pc + XLEN'(4);
            end

            if (rsp_accept) begin
                pf_head <= pf_head + PW'(1);
            end

            if (i_redirect_valid) begin
                // Request valid is held low here, so this load never races
                // the increment above.
                fetch_pc <= i_redirect_pc & ~XLEN'(3);
                q_head   <= '0;
                q_tail   <= '0;
                count    <= '0;
                state    <= (out_next != '0) ? FLUSH : FETCH;
            end else begin
                if (enq) begin
                    q_data[q_tail] <= i_im_rsp_data;
                    q_pc[q_tail]   <= pc_fifo[pf_head];
                    q_tail         <= q_tail + PW'(1);
                end
                if (deq) begin
                    q_head <= q_head + PW'(1);
                end
                count <= count + CW'(enq) - CW'(deq);
                if ((state == FLUSH) && (out_next == '0)) begin
                    state <= FETCH;
                end
            end
        end
    end

endmodule

// File: tb/tb_prefetch_unit.sv
// Directed bench for prefetch_unit with a 1-cycle-latency in-order memory model.
module tb_prefetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        o_im_req_valid;
    logic        i_im_req_ready = 1'b1;
    logic [31:0] o_im_req_addr;
    logic        i_im_rsp_valid = 1'b0;
    logic [31:0] i_im_rsp_data = '0;
    logic        o_ins_valid;
    logic        i_ins_ready = 1'b1;
    logic [31:0] o_ins_data;
    logic [31:0] o_ins_pc;
    logic        i_redirect_valid = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic        o_flushing;
    logic [2:0]  o_outstanding;

    int checks   = 0;
    int failures = 0;

    logic        rsp_en = 1'b0;
    logic [31:0] pending[$];
    logic [31:0] req_log[$];
    logic [31:0] ins_pc_log[$];
    logic [31:0] ins_data_log[$];

    prefetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk              (clk),
        .rst              (rst),
        .o_im_req_valid   (o_im_req_valid),
        .i_im_req_ready   (i_im_req_ready),
        .o_im_req_addr    (o_im_req_addr),
        .i_im_rsp_valid   (i_im_rsp_valid),
        .i_im_rsp_data    (i_im_rsp_data),
        .o_ins_valid      (o_ins_valid),
        .i_ins_ready      (i_ins_ready),
        .o_ins_data       (o_ins_data),
        .o_ins_pc         (o_ins_pc),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .o_flushing       (o_flushing),
        .o_outstanding    (o_outstanding)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'hDEAD_BEEF;
    endfunction

    // One clock cycle: sample handshakes, take the edge, then present the
    // memory response for the next cycle. Returns just after the negedge.
    task automatic cycle();
        logic        fire;
        logic [31:0] addr;
        #1;
        fire = o_im_req_valid && i_im_req_ready;
        addr = o_im_req_addr;
        if (o_ins_valid && i_ins_ready) begin
            ins_pc_log.push_back(o_ins_pc);
            ins_data_log.push_back(o_ins_data);
        end
        @(posedge clk);
        if (fire) begin
            pending.push_back(addr);
            req_log.push_back(addr);
        end
        @(negedge clk);
        if (rst) begin
            pending.delete();
            i_im_rsp_valid = 1'b0;
        end else if (rsp_en && pending.size() > 0) begin
            i_im_rsp_valid = 1'b1;
            i_im_rsp_data  = mem_word(pending.pop_front());
        end else begin
            i_im_rsp_valid = 1'b0;
        end
    endtask

    task automatic clear_logs();
        req_log.delete();
        ins_pc_log.delete();
        ins_data_log.delete();
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        rsp_en           = 1'b0;
        i_redirect_valid = 1'b0;
        i_im_req_ready   = 1'b1;
        i_ins_ready      = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) cycle();
        #1;
        checks++; if (o_im_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%0h exp=0", o_im_req_valid); end
        checks++; if (o_ins_valid !== 1'b0) begin failures++; $display("FAIL reset_ins_valid got=%0h exp=0", o_ins_valid); end
        checks++; if (o_ins_data !== 32'h0) begin failures++; $display("FAIL reset_ins_data got=%0h exp=0", o_ins_data); end
        checks++; if (o_ins_pc !== 32'h0) begin failures++; $display("FAIL reset_ins_pc got=%0h exp=0", o_ins_pc); end
        checks++; if (o_flushing !== 1'b0) begin failures++; $display("FAIL reset_flushing got=%0h exp=0", o_flushing); end
        checks++; if (o_outstanding !== 3'd0) begin failures++; $display("FAIL reset_outstanding got=%0d exp=0", o_outstanding); end
        checks++; if (o_im_req_addr !== 32'h0) begin failures++; $display("FAIL reset_req_addr got=%0h exp=0", o_im_req_addr); end
        rst = 1'b0;
        clear_logs();
        #1;
        checks++; if (o_im_req_valid !== 1'b1) begin failures++; $display("FAIL first_req_valid got=%0h exp=1", o_im_req_valid); end
        checks++; if (o_im_req_addr !== 32'h0) begin failures++; $display("FAIL first_req_addr got=%0h exp=0", o_im_req_addr); end
    endtask

    task automatic test_stream();
        do_reset();
        rsp_en = 1'b1;
        repeat (12) cycle();
        checks++; if (req_log.size() != 12) begin failures++; $display("FAIL stream_req_count got=%0d exp=12", req_log.size()); end
        checks++; if (ins_pc_log.size() != 10) begin failures++; $display("FAIL stream_ins_count got=%0d exp=10", ins_pc_log.size()); end
        for (int i = 0; i < 10 && i < ins_pc_log.size(); i++) begin
            checks++; if (ins_pc_log[i] !== 32'(4 * i)) begin failures++; $display("FAIL stream_pc[%0d] got=%0h exp=%0h", i, ins_pc_log[i], 4 * i); end
            checks++; if (ins_data_log[i] !== mem_word(32'(4 * i))) begin failures++; $display("FAIL stream_data[%0d] got=%0h exp=%0h", i, ins_data_log[i], mem_word(32'(4 * i))); end
        end
        for (int i = 0; i < 12 && i < req_log.size(); i++) begin
            checks++; if (req_log[i] !== 32'(4 * i)) begin failures++; $display("FAIL stream_req[%0d] got=%0h exp=%0h", i, req_log[i], 4 * i); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        rsp_en      = 1'b1;
        i_ins_ready = 1'b0;
        repeat (10) cycle();
        #1;
        checks++; if (req_log.size() != 4) begin failures++; $display("FAIL bp_req_count got=%0d exp=4", req_log.size()); end
        for (int i = 0; i < 4 && i < req_log.size(); i++) begin
            checks++; if (req_log[i] !== 32'(4 * i)) begin failures++; $display("FAIL bp_req[%0d] got=%0h exp=%0h", i, req_log[i], 4 * i); end
        end
        checks++; if (o_im_req_valid !== 1'b0) begin failures++; $display("FAIL bp_req_valid got=%0h exp=0", o_im_req_valid); end
        checks++; if (o_ins_valid !== 1'b1) begin failures++; $display("FAIL bp_ins_valid got=%0h exp=1", o_ins_valid); end
        checks++; if (o_ins_pc !== 32'h0) begin failures++; $display("FAIL bp_head_pc got=%0h exp=0", o_ins_pc); end
        checks++; if (o_outstanding !== 3'd0) begin failures++; $display("FAIL bp_outstanding got=%0d exp=0", o_outstanding); end
        i_ins_ready = 1'b1;
        repeat (4) cycle();
        checks++; if (ins_pc_log.size() != 4) begin failures++; $display("FAIL bp_drain_count got=%0d exp=4", ins_pc_log.size()); end
        for (int i = 0; i < 4 && i < ins_pc_log.size(); i++) begin
            checks++; if (ins_pc_log[i] !== 32'(4 * i)) begin failures++; $display("FAIL bp_drain_pc[%0d] got=%0h exp=%0h", i, ins_pc_log[i], 4 * i); end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        cycle();
        rsp_en = 1'b1;
        cycle();
        #1;
        checks++; if (o_outstanding !== 3'd2) begin failures++; $display("FAIL redir_pre_outstanding got=%0d exp=2", o_outstanding); end
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 32'h0000_0103;
        #1;
        checks++; if (o_im_req_valid !== 1'b0) begin failures++; $display("FAIL redir_cycle_req_valid got=%0h exp=0", o_im_req_valid); end
        cycle();
        i_redirect_valid = 1'b0;
        #1;
        checks++; if (o_flushing !== 1'b1) begin failures++; $display("FAIL redir_flushing got=%0h exp=1", o_flushing); end
        checks++; if (o_outstanding !== 3'd1) begin failures++; $display("FAIL redir_outstanding got=%0d exp=1", o_outstanding); end
        checks++; if (o_ins_valid !== 1'b0) begin failures++; $display("FAIL redir_ins_valid got=%0h exp=0", o_ins_valid); end
        checks++; if (o_im_req_valid !== 1'b0) begin failures++; $display("FAIL redir_flush_req_valid got=%0h exp=0", o_im_req_valid); end
        cycle();
        #1;
        checks++; if (o_flushing !== 1'b0) begin failures++; $display("FAIL redir_flush_done got=%0h exp=0", o_flushing); end
        checks++; if (o_outstanding !== 3'd0) begin failures++; $display("FAIL redir_drained got=%0d exp=0", o_outstanding); end
        checks++; if (o_im_req_valid !== 1'b1) begin failures++; $display("FAIL redir_resume_valid got=%0h exp=1", o_im_req_valid); end
        checks++; if (o_im_req_addr !== 32'h100) begin failures++; $display("FAIL redir_resume_addr got=%0h exp=100", o_im_req_addr); end
        checks++; if (ins_pc_log.size() != 0) begin failures++; $display("FAIL redir_stale_ins got=%0d exp=0", ins_pc_log.size()); end
        repeat (3) cycle();
        checks++; if (ins_pc_log.size() != 1) begin failures++; $display("FAIL redir_new_count got=%0d exp=1", ins_pc_log.size()); end
        if (ins_pc_log.size() > 0) begin
            checks++; if (ins_pc_log[0] !== 32'h100) begin failures++; $display("FAIL redir_new_pc got=%0h exp=100", ins_pc_log[0]); end
            checks++; if (ins_data_log[0] !== mem_word(32'h100)) begin failures++; $display("FAIL redir_new_data got=%0h exp=%0h", ins_data_log[0], mem_word(32'h100)); end
        end
    endtask

    task automatic test_redirect_queue();
        int n_before;
        do_reset();
        rsp_en      = 1'b1;
        i_ins_ready = 1'b0;
        repeat (8) cycle();
        i_ins_ready      = 1'b1;
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 32'h0000_0043;
        n_before         = ins_pc_log.size();
        cycle();
        i_redirect_valid = 1'b0;
        #1;
        checks++; if (o_ins_valid !== 1'b0) begin failures++; $display("FAIL rq_ins_valid got=%0h exp=0", o_ins_valid); end
        checks++; if (o_flushing !== 1'b0) begin failures++; $display("FAIL rq_flushing got=%0h exp=0", o_flushing); end
        checks++; if (o_im_req_valid !== 1'b1) begin failures++; $display("FAIL rq_req_valid got=%0h exp=1", o_im_req_valid); end
        checks++; if (o_im_req_addr !== 32'h40) begin failures++; $display("FAIL rq_req_addr got=%0h exp=40", o_im_req_addr); end
        checks++; if (ins_pc_log.size() != n_before + 1) begin failures++; $display("FAIL rq_consumed got=%0d exp=%0d", ins_pc_log.size(), n_before + 1); end
    endtask

    task automatic test_flush_redirect();
        int n;
        do_reset();
        repeat (2) cycle();
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 32'h200;
        cycle();
        i_redirect_pc = 32'h300;
        #1;
        checks++; if (o_flushing !== 1'b1) begin failures++; $display("FAIL fr_flushing_1 got=%0h exp=1", o_flushing); end
        cycle();
        i_redirect_valid = 1'b0;
        #1;
        checks++; if (o_flushing !== 1'b1) begin failures++; $display("FAIL fr_flushing_2 got=%0h exp=1", o_flushing); end
        rsp_en = 1'b1;
        req_log.delete();
        n = 0;
        while (!o_im_req_valid && n < 20) begin
            cycle();
            #1;
            n++;
        end
        checks++; if (o_im_req_valid !== 1'b1) begin failures++; $display("FAIL fr_resume_timeout got=%0h exp=1", o_im_req_valid); end
        checks++; if (o_im_req_addr !== 32'h300) begin failures++; $display("FAIL fr_resume_addr got=%0h exp=300", o_im_req_addr); end
        cycle();
        checks++; if (req_log.size() != 1 || req_log[0] !== 32'h300) begin failures++; $display("FAIL fr_first_req got_n=%0d exp first=300", req_log.size()); end
    endtask

    task automatic test_wrap();
        do_reset();
        rsp_en           = 1'b1;
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 32'hFFFF_FFFC;
        cycle();
        i_redirect_valid = 1'b0;
        #1;
        checks++; if (o_flushing !== 1'b0) begin failures++; $display("FAIL wrap_flushing got=%0h exp=0", o_flushing); end
        checks++; if (o_im_req_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_addr0 got=%0h exp=fffffffc", o_im_req_addr); end
        repeat (4) cycle();
        checks++; if (req_log.size() < 2 || req_log[0] !== 32'hFFFF_FFFC || req_log[1] !== 32'h0) begin failures++; $display("FAIL wrap_req_seq got_n=%0d exp fffffffc,0", req_log.size()); end
        checks++; if (ins_pc_log.size() != 2 || ins_pc_log[0] !== 32'hFFFF_FFFC || ins_pc_log[1] !== 32'h0) begin failures++; $display("FAIL wrap_ins_seq got_n=%0d exp fffffffc,0", ins_pc_log.size()); end
    endtask

    task automatic test_midrun_reset();
        do_reset();
        rsp_en      = 1'b1;
        i_ins_ready = 1'b0;
        cycle();
        rsp_en = 1'b0;
        repeat (3) cycle();
        #1;
        checks++; if (o_outstanding !== 3'd3) begin failures++; $display("FAIL mr_outstanding got=%0d exp=3", o_outstanding); end
        checks++; if (o_ins_data !== mem_word(32'h0)) begin failures++; $display("FAIL mr_head_data got=%0h exp=%0h", o_ins_data, mem_word(32'h0)); end
        rst = 1'b1;
        cycle();
        #1;
        checks++; if (o_im_req_valid !== 1'b0) begin failures++; $display("FAIL mr_req_valid got=%0h exp=0", o_im_req_valid); end
        checks++; if (o_ins_valid !== 1'b0) begin failures++; $display("FAIL mr_ins_valid got=%0h exp=0", o_ins_valid); end
        checks++; if (o_ins_data !== 32'h0) begin failures++; $display("FAIL mr_ins_data got=%0h exp=0", o_ins_data); end
        checks++; if (o_ins_pc !== 32'h0) begin failures++; $display("FAIL mr_ins_pc got=%0h exp=0", o_ins_pc); end
        checks++; if (o_flushing !== 1'b0) begin failures++; $display("FAIL mr_flushing got=%0h exp=0", o_flushing); end
        checks++; if (o_outstanding !== 3'd0) begin failures++; $display("FAIL mr_out_zero got=%0d exp=0", o_outstanding); end
        checks++; if (o_im_req_addr !== 32'h0) begin failures++; $display("FAIL mr_req_addr got=%0h exp=0", o_im_req_addr); end
        rst = 1'b0;
        #1;
        checks++; if (o_im_req_valid !== 1'b1 || o_im_req_addr !== 32'h0) begin failures++; $display("FAIL mr_restart got valid=%0h addr=%0h exp valid=1 addr=0", o_im_req_valid, o_im_req_addr); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_queue();
        test_flush_redirect();
        test_wrap();
        test_midrun_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prefetch_unit.md
PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data and address width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning instruction queue entries and maximum outstanding requests; legal values are powers of two, 2 or more.
REQ-003 SHALL have parameter RESET_PC, default 0, meaning the first fetch address after reset.
REQ-004 SHALL have one clock; reset is synchronous and active-high. Ports: clk  input  1  clock; rst  input  1  synchronous active-high reset.
REQ-005 SHALL have these request ports: o_im_req_valid  output  1  fetch request; i_im_req_ready  input  1  memory accepts request; o_im_req_addr  output  XLEN  fetch address.
REQ-006 SHALL have these response ports: i_im_rsp_valid  input  1  response beat, in request order, no backpressure; i_im_rsp_data  input  XLEN  instruction word.
REQ-007 SHALL have these decode-side ports: o_ins_valid  output  1  queue head valid; i_ins_ready  input  1  decode consumes head; o_ins_data  output  XLEN  head instruction; o_ins_pc  output  XLEN  head address.
REQ-008 SHALL have these redirect ports: i_redirect_valid  input  1  branch/jump redirect; i_redirect_pc  input  XLEN  new fetch address.
REQ-009 SHALL have these status ports: o_flushing  output  1  discarding stale responses; o_outstanding  output  $clog2(DEPTH)+1  requests in flight.

Function
REQ-010 SHALL implement FSM states FETCH and FLUSH.
REQ-011 SHALL assert o_im_req_valid only when all hold: state FETCH, (queue count + outstanding) < DEPTH, and i_redirect_valid low. o_im_req_valid SHALL be combinational from these conditions.
REQ-012 SHALL hold o_im_req_addr equal to fetch_pc. On request handshake (valid & ready), fetch_pc SHALL advance by 4, modulo 2^XLEN; 0xFFFFFFFC wraps to 0x0.
REQ-013 SHALL increment outstanding on each request handshake and decrement it on each i_im_rsp_valid; when both occur in the same cycle, outstanding SHALL be unchanged.
REQ-014 In FETCH, each i_im_rsp_valid SHALL enqueue {i_im_rsp_data, pc}, with pc the address of the oldest outstanding request (a per-slot PC FIFO of DEPTH entries).
REQ-015 SHALL register the queue: a response accepted in cycle N SHALL be visible on o_ins_valid/o_ins_data/o_ins_pc in cycle N+1.
REQ-016 SHALL drive o_ins_valid = (count != 0); the head SHALL dequeue on o_ins_valid & i_ins_ready. Simultaneous enqueue and dequeue SHALL leave count unchanged and preserve order.
REQ-017 The queue SHALL never overflow, by the credit rule of REQ-011.
REQ-018 Redirect SHALL take effect in the same cycle: the queue is cleared (count=0 next cycle), fetch_pc is loaded with {i_redirect_pc[XLEN-1:2],2'b00}, and no request is issued that cycle.
REQ-019 Redirect state change: if outstanding after this cycle is nonzero, state SHALL go to FLUSH; otherwise it SHALL stay in FETCH.
REQ-020 In FLUSH, responses SHALL be discarded (not enqueued) and no requests issued. When outstanding reaches 0, the FSM SHALL return to FETCH on the next cycle.
REQ-021 A redirect while in FLUSH SHALL reload fetch_pc and keep state FLUSH.
REQ-022 A response arriving in the same cycle as a redirect SHALL be discarded.
REQ-023 A dequeue handshake in the redirect cycle SHALL count as consumed; no entry SHALL survive the redirect.
REQ-024 SHALL ignore i_im_rsp_valid while outstanding == 0 (protocol violation): no enqueue and no counter underflow.
REQ-025 SHALL drive o_flushing = (state == FLUSH).

Reset
REQ-026 While rst is high, the block SHALL hold: state FETCH, fetch_pc = RESET_PC, count = 0, outstanding = 0, queue storage 0.
REQ-027 While rst is high, outputs SHALL be: o_im_req_valid = 0, o_ins_valid = 0, o_ins_data = 0, o_ins_pc = 0, o_flushing = 0, o_outstanding = 0, o_im_req_addr = RESET_PC.
REQ-028 In the first cycle after rst deasserts, o_im_req_valid SHALL be 1 with o_im_req_addr = RESET_PC.
REQ-029 rst asserted mid-operation SHALL abandon all in-flight state. Responses for pre-reset requests are the memory's responsibility to squash.

Verification
REQ-030 Stream: ready always 1, 1-cycle response latency, decode always ready, RESET_PC=0 -> requests 0x0,0x4,0x8...; o_ins_pc follows the same sequence; o_ins_data matches memory words; steady state is 1 instruction/cycle.
REQ-031 Backpressure: i_ins_ready=0, DEPTH=4 -> exactly 4 requests issued (0x0..0xC); o_im_req_valid stays 0; releasing ready drains in order 0x0,0x4,0x8,0xC.
REQ-032 Redirect with 2 in flight: i_redirect_pc=0x100 -> queue empty next cycle; o_flushing=1 until 2 responses are dropped; next request address is 0x100; no stale instruction is presented.
REQ-033 Redirect while in FLUSH to 0x200, then 0x300 -> first fetch after the flush is 0x300.
REQ-034 Wrap: redirect to 0xFFFFFFFC -> request addresses 0xFFFFFFFC then 0x00000000.
REQ-035 Mid-run reset with 3 outstanding -> all outputs equal their reset values next cycle; fetch restarts at RESET_PC.
